// File: rtl/shift_operand_stage.sv
// shift_operand_stage: two-entry skid-buffered register stage feeding the barrel shifter
module shift_operand_stage #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [3:0]       i_fs,
  input  logic [3:0]       i_sel_a,
  input  logic [3:0]       i_opr_a,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [3:0]       o_fs,
  output logic [3:0]       o_sel_a,
  output logic [3:0]       o_opr_a,
  output logic             o_is_shift
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] skid_data;
  logic [3:0] skid_fs, skid_sel_a, skid_opr_a;
  logic skid_is_shift;
  logic accept, pop, load_in, load_skid, promote;
  function automatic logic shift_code(input logic [3:0] fs);
    return fs inside {4'b1100, 4'b1110, 4'b1101, 4'b1111, 4'b0010,
                      4'b0100, 4'b0110, 4'b1000, 4'b1010};
  endfunction
  assign o_valid = state != EMPTY;
  assign accept = i_valid & o_ready;
  assign pop = o_valid & i_ready;
  always_comb begin
    state_n = state;
    load_in = 1'b0;
    load_skid = 1'b0;
    promote = 1'b0;
    if (!i_flush)
      case (state)
        EMPTY: begin
          state_n = accept ? ONE : EMPTY;
          load_in = accept;
        end
        ONE: begin
          state_n = accept ? (pop ? ONE : TWO) : (pop ? EMPTY : ONE);
          load_in = accept & pop;
          load_skid = accept & ~pop;
        end
        TWO: begin
          state_n = pop ? ONE : TWO;
          promote = pop;
        end
        default: state_n = EMPTY;
      endcase
    else
      state_n = EMPTY;
  end
  // ready is registered from the next state so it never depends on i_ready combinationally
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= EMPTY;
      o_ready <= 1'b1;
    end else begin
      state <= state_n;
      o_ready <= state_n != TWO;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data <= '0;
      o_fs <= '0;
      o_sel_a <= '0;
      o_opr_a <= '0;
      o_is_shift <= 1'b0;
      skid_data <= '0;
      skid_fs <= '0;
      skid_sel_a <= '0;
      skid_opr_a <= '0;
      skid_is_shift <= 1'b0;
    end else begin
      if (load_in) begin
        o_data <= i_data;
        o_fs <= i_fs;
        o_sel_a <= i_sel_a;
        o_opr_a <= i_opr_a;
        o_is_shift <= shift_code(i_fs);
      end else if (promote) begin
        o_data <= skid_data;
        o_fs <= skid_fs;
        o_sel_a <= skid_sel_a;
        o_opr_a <= skid_opr_a;
        o_is_shift <= skid_is_shift;
      end
      if (load_skid) begin
        skid_data <= i_data;
        skid_fs <= i_fs;
        skid_sel_a <= i_sel_a;
        skid_opr_a <= i_opr_a;
        skid_is_shift <= shift_code(i_fs);
      end
    end
  end
endmodule

// File: tb/tb_shift_operand_stage.sv
// tb_shift_operand_stage: randomized and directed scoreboard bench for shift_operand_stage
module tb_shift_operand_stage;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0] fs;
    logic [3:0] sel;
    logic [3:0] opr;
    logic sh;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic i_valid = 1'b0;
  logic i_ready = 1'b0;
  logic [31:0] i_data = '0;
  logic [3:0] i_fs = '0;
  logic [3:0] i_sel_a = '0;
  logic [3:0] i_opr_a = '0;
  logic o_ready, o_valid, o_is_shift;
  logic [31:0] o_data;
  logic [3:0] o_fs, o_sel_a, o_opr_a;
  ent_t q[$];
  int pend = 0;
  int n_cmp = 0;
  int n_fail = 0;
  shift_operand_stage #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_fs(i_fs), .i_sel_a(i_sel_a), .i_opr_a(i_opr_a),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_fs(o_fs),
    .o_sel_a(o_sel_a), .o_opr_a(o_opr_a), .o_is_shift(o_is_shift)
  );
  always #5 clk = ~clk;
  function automatic logic ref_shift(input logic [3:0] fs);
    logic [3:0] codes[9] = '{4'hC, 4'hE, 4'hD, 4'hF, 4'h2, 4'h4, 4'h6, 4'h8, 4'hA};
    foreach (codes[k]) if (codes[k] == fs) return 1'b1;
    return 1'b0;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  // the model knows the stage holds q.size() entries after each edge; an accept needs room
  task automatic drive(input logic v, input logic r, input logic f, input logic [31:0] d,
                       input logic [3:0] fs, input logic [3:0] sel, input logic [3:0] opr);
    i_valid = v; i_ready = r; flush = f; i_data = d; i_fs = fs; i_sel_a = sel; i_opr_a = opr;
    if (f) begin
      q.delete();
      pend = 0;
    end else begin
      pend = (v && q.size() < 2) ? 1 : 0;
      if (pend == 1) q.push_back('{d, fs, sel, opr, ref_shift(fs)});
    end
  endtask
  task automatic step(input logic v, input logic r, input logic f, input logic [31:0] d,
                      input logic [3:0] fs, input logic [3:0] sel, input logic [3:0] opr);
    @(posedge clk);
    #1;
    drive(v, r, f, d, fs, sel, opr);
  endtask
  always @(negedge clk) begin
    int occ;
    if (!rst && !flush) begin
      occ = q.size() - pend;
      chk("o_valid", {31'b0, o_valid}, {31'b0, occ > 0});
      chk("o_ready", {31'b0, o_ready}, {31'b0, occ < 2});
      if (occ > 0) begin
        chk("o_data", o_data, q[0].d);
        chk("o_fs", {28'b0, o_fs}, {28'b0, q[0].fs});
        chk("o_sel_a", {28'b0, o_sel_a}, {28'b0, q[0].sel});
        chk("o_opr_a", {28'b0, o_opr_a}, {28'b0, q[0].opr});
        chk("o_is_shift", {31'b0, o_is_shift}, {31'b0, q[0].sh});
        if (i_ready) void'(q.pop_front());
      end
    end
  end
  initial begin
    i_valid = 1'b1;
    i_data = 32'hDEADBEEF;
    i_fs = 4'hC;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_data", o_data, 32'd0);
    chk("rst_fields", {19'b0, o_fs, o_sel_a, o_opr_a, o_is_shift}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 0, 0, 32'hDEADBEEF, 4'hC, 4'h1, 4'h3);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h100 + i, 4'b1100, 4'(i), 4'(i));
    repeat (2) step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 32'h1, 4'h2, 4'h5, 4'h0);
    step(1, 0, 0, 32'h2, 4'h3, 4'h6, 4'hF);
    repeat (3) step(1, 0, 0, 32'hBAD0, 4'h0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'hA0, 4'b0000, 1, 1);
    step(1, 1, 0, 32'hA1, 4'b0011, 2, 2);
    step(1, 1, 0, 32'hA2, 4'b1010, 3, 3);
    step(1, 1, 0, 32'hA3, 4'b0010, 4, 4);
    repeat (2) step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 32'hC1, 4'h4, 0, 0);
    step(1, 0, 0, 32'hC2, 4'h5, 0, 0);
    step(1, 1, 1, 32'hF1F1F1F1, 4'hF, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 32'h55, 4'h8, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    pend = 0;
    #1;
    chk("async_rst_valid", {31'b0, o_valid}, 32'd0);
    chk("async_rst_ready", {31'b0, o_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0),
           $urandom, 4'($urandom), 4'($urandom), 4'($urandom));
    repeat (3) step(0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_operand_stage.md
Name: shift_operand_stage

Overview:
- Registered pipeline stage directly upstream of the barrel shifter in the RISC datapath.
- Captures the operand, function select, source select and shift amount from decode/register-read, then presents them as stable inputs to the barrel unit.
- Uses a 2-entry skid buffer with valid/ready handshakes on both sides, so decode sees full throughput and execute stalls never drop or duplicate an operation.
- Also pre-decodes whether the held function select is a shift/rotate operation.

Parameters:
- WIDTH, 32, operand/data width in bits.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_flush  input  1  synchronous flush; discards all buffered entries.
- i_valid  input  1  upstream holds a valid operation.
- o_ready  output  1  stage can accept an operation this cycle (registered).
- i_data  input  WIDTH  operand to be shifted/rotated.
- i_fs  input  4  function select.
- i_sel_a  input  4  source register select for operand A.
- i_opr_a  input  4  shift/rotate amount.
- o_valid  output  1  head entry valid toward barrel/execute.
- i_ready  input  1  downstream consumes head entry this cycle.
- o_data  output  WIDTH  head entry operand.
- o_fs  output  4  head entry function select.
- o_sel_a  output  4  head entry source select.
- o_opr_a  output  4  head entry shift amount.
- o_is_shift  output  1  head entry fs is a shift/rotate code.

Behaviour:
- Reset (async, i_rst=1):
  - o_valid=0; o_data, o_fs, o_sel_a, o_opr_a = 0; o_is_shift=0; o_ready=1.
  - Skid entry cleared; state EMPTY.
  - Asserting reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Handshakes:
  - Accept occurs when i_valid & o_ready at a clock edge.
  - Pop occurs when o_valid & i_ready at a clock edge.
  - Payload is captured only on accept.
  - Outputs are stable while o_valid=1 and i_ready=0.
- Storage: head register (drives outputs) plus skid register. Entries leave in strict FIFO order.
- States:
  - EMPTY: o_valid=0, o_ready=1. Accept -> ONE (head loaded). No accept -> EMPTY.
  - ONE: o_valid=1, o_ready=1.
    - Accept & pop -> ONE; head reloaded with new input.
    - Accept only -> TWO; new input goes to skid, o_ready=0 next cycle.
    - Pop only -> EMPTY.
    - Neither -> ONE.
  - TWO: o_valid=1, o_ready=0; accept impossible.
    - Pop -> ONE; skid moves to head, o_ready=1 next cycle.
    - No pop -> TWO.
- Latency: 1 cycle from accept (in EMPTY) to o_valid=1. Sustained throughput is 1 op/cycle while i_ready=1.
- o_ready is a registered signal: it equals (next state != TWO). It has no combinational path from i_ready.
- o_is_shift:
  - Registered alongside the head entry.
  - Value is 1 iff fs is one of 1100, 1110, 1101, 1111, 0010, 0100, 0110, 1000, 1010; otherwise 0.
  - It moves with the entry when the skid entry is promoted to head.
- Flush:
  - i_flush=1 at an edge -> state EMPTY, o_valid=0, o_ready=1 next cycle.
  - Flush takes priority over a simultaneous accept or pop. The input is dropped and the pop is not counted as a second consumption.
  - Payload outputs hold their last values after flush; only o_valid defines validity.
- While o_valid=0, payload outputs are don't-care for consumers. The implementation holds the last values (no toggling).
- i_opr_a is stored unmodified: all 16 amounts, including 0, pass through.

Test Plan:
- Reset with i_valid=1, i_data=32'hDEADBEEF applied -> o_valid=0, o_ready=1, outputs 0. After release, first edge accepts; next cycle o_data=32'hDEADBEEF, o_valid=1.
- Stream 8 ops with i_ready=1 every cycle (fs=4'b1100, opr_a=0..7) -> 8 consecutive o_valid cycles, order preserved, o_is_shift=1 each, o_ready never deasserts.
- Hold i_ready=0 and send A=32'h1, then B=32'h2 -> state TWO, o_ready=0, o_data=32'h1 stable. i_ready=1 for one cycle -> o_data=32'h2, o_ready=1 next cycle, no loss or duplicate.
- Send fs=4'b0000 and fs=4'b0011 -> o_is_shift=0. Send fs=4'b1010 and fs=4'b0010 -> o_is_shift=1.
- In TWO, assert i_flush together with i_ready=1 and i_valid=1 -> next cycle o_valid=0, o_ready=1. The flushed input never appears on the outputs.
- Assert i_rst asynchronously between edges while in ONE -> o_valid drops to 0 immediately, before the next edge.
